// File: rtl/sram_arb_bridge_if.sv
// Shared memory-side bus for sram_arb_bridge: req/addr_ok/data_ok handshake.
// The master modport is the bridge and the slave modport is the memory.
interface sram_arb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                mem_req;
  logic                mem_wr;
  logic [DATA_W/8-1:0] mem_wstrb;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic                mem_addr_ok;
  logic                mem_data_ok;
  logic [DATA_W-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    input  mem_addr_ok, mem_data_ok, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
    output mem_addr_ok, mem_data_ok, mem_rdata
  );
endinterface

// File: rtl/sram_arb_bridge.sv
// Merges CPU inst/data SRAM ports onto one shared bus with a single outstanding transaction.
// Define SRAM_ARB_RR_EN for round-robin arbitration instead of fixed data-over-inst priority.
//
// state | meaning
// IDLE  | no transaction; arbitrate between data and inst requests
// REQ   | mem_req high with latched fields, waiting for mem_addr_ok
// WAIT  | request accepted by bus, waiting for mem_data_ok
// RESP  | owner's ready pulse cycle (suppressed if killed); back to IDLE next
module sram_arb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cancel,
  input  logic                inst_en,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic [DATA_W-1:0]   inst_rdata,
  output logic                inst_ready,
  input  logic                data_en,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                data_ready,
  sram_arb_bridge_if.master   mem
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_INST, OWN_DATA} owner_t;

  state_t state;
  owner_t owner;
  logic   kill;
  logic   grant_data;
  logic   grant_inst;

`ifdef SRAM_ARB_RR_EN
  logic last_data;

  // On a tie the port that was not granted last wins.
  always_comb begin
    grant_data = data_en && (!inst_en || !last_data);
    grant_inst = inst_en && !grant_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_data <= 1'b0;
    end else if (state == IDLE && (grant_data || grant_inst)) begin
      last_data <= grant_data;
    end
  end
`else
  always_comb begin
    grant_data = data_en;
    grant_inst = inst_en && !data_en;
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      owner          <= OWN_NONE;
      kill           <= 1'b0;
      mem.mem_req    <= 1'b0;
      mem.mem_wr     <= 1'b0;
      mem.mem_wstrb  <= '0;
      mem.mem_addr   <= '0;
      mem.mem_wdata  <= '0;
      inst_rdata     <= '0;
      data_rdata     <= '0;
      inst_ready     <= 1'b0;
      data_ready     <= 1'b0;
    end else begin
      inst_ready <= 1'b0;
      data_ready <= 1'b0;
      // An accepted bus request cannot be withdrawn; cancel only hides the response.
      if (cancel && owner == OWN_INST && state != IDLE) begin
        kill <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (grant_data) begin
            mem.mem_req   <= 1'b1;
            mem.mem_wr    <= |data_wen;
            mem.mem_wstrb <= data_wen;
            mem.mem_addr  <= data_addr;
            mem.mem_wdata <= data_wdata;
            owner         <= OWN_DATA;
            state         <= REQ;
          end else if (grant_inst) begin
            mem.mem_req   <= 1'b1;
            mem.mem_wr    <= 1'b0;
            mem.mem_wstrb <= '0;
            mem.mem_addr  <= inst_addr;
            mem.mem_wdata <= '0;
            owner         <= OWN_INST;
            state         <= REQ;
          end
        end
        REQ: begin
          if (mem.mem_addr_ok) begin
            mem.mem_req <= 1'b0;
            state       <= WAIT;
          end
        end
        WAIT: begin
          if (mem.mem_data_ok) begin
            // Ready is registered here so it is high exactly during RESP.
            if (owner == OWN_INST) begin
              inst_rdata <= mem.mem_rdata;
              inst_ready <= !(kill || cancel);
            end else begin
              if (!mem.mem_wr) begin
                data_rdata <= mem.mem_rdata;
              end
              data_ready <= 1'b1;
            end
            state <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
          owner <= OWN_NONE;
          kill  <= 1'b0;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sram_arb_bridge.sv
// Bench for sram_arb_bridge: directed scenarios plus random single-port transactions,
// checked against a transaction-level expectation of bus fields, ready timing and rdata.
module tb_sram_arb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
`ifdef SRAM_ARB_RR_EN
  localparam bit RR_MODE = 1'b1;
`else
  localparam bit RR_MODE = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          cancel;
  logic          inst_en;
  logic [AW-1:0] inst_addr;
  logic [DW-1:0] inst_rdata;
  logic          inst_ready;
  logic          data_en;
  logic [3:0]    data_wen;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic [DW-1:0] data_rdata;
  logic          data_ready;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DW-1:0] exp_inst_rdata;
  logic [DW-1:0] exp_data_rdata;

  sram_arb_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  sram_arb_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .cancel     (cancel),
    .inst_en    (inst_en),
    .inst_addr  (inst_addr),
    .inst_rdata (inst_rdata),
    .inst_ready (inst_ready),
    .data_en    (data_en),
    .data_wen   (data_wen),
    .data_addr  (data_addr),
    .data_wdata (data_wdata),
    .data_rdata (data_rdata),
    .data_ready (data_ready),
    .mem        (mem_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    chk("ready_excl", 64'(inst_ready & data_ready), 64'd0);
  endtask

  task automatic check_out(input string tag, input bit exp_i, input bit exp_d);
    chk({tag, "_iready"}, 64'(inst_ready), 64'(exp_i));
    chk({tag, "_dready"}, 64'(data_ready), 64'(exp_d));
    chk({tag, "_irdata"}, 64'(inst_rdata), 64'(exp_inst_rdata));
    chk({tag, "_drdata"}, 64'(data_rdata), 64'(exp_data_rdata));
  endtask

  // Acts as the memory from the first REQ cycle until the cycle after data_ok (RESP).
  task automatic mem_serve(input string tag, input logic [AW-1:0] e_addr, input bit e_wr,
                           input logic [3:0] e_strb, input logic [DW-1:0] e_wdata,
                           input int ao_d, input int do_d, input logic [DW-1:0] rd,
                           input bit spurious, input bit do_cancel, input bit drop_en);
    chk({tag, "_req"},   64'(mem_if.mem_req),   64'd1);
    chk({tag, "_addr"},  64'(mem_if.mem_addr),  64'(e_addr));
    chk({tag, "_wr"},    64'(mem_if.mem_wr),    64'(e_wr));
    chk({tag, "_wstrb"}, 64'(mem_if.mem_wstrb), 64'(e_strb));
    if (e_wr) chk({tag, "_wdata"}, 64'(mem_if.mem_wdata), 64'(e_wdata));
    for (int k = 0; k < ao_d; k++) begin
      mem_if.mem_data_ok = spurious;
      mem_if.mem_rdata   = 32'hBAD0_0000 | k;
      step();
      chk({tag, "_bp_req"},  64'(mem_if.mem_req),  64'd1);
      chk({tag, "_bp_addr"}, 64'(mem_if.mem_addr), 64'(e_addr));
      check_out({tag, "_bp"}, 1'b0, 1'b0);
    end
    mem_if.mem_data_ok = 1'b0;
    mem_if.mem_addr_ok = 1'b1;
    step();
    mem_if.mem_addr_ok = 1'b0;
    if (drop_en) begin
      inst_en = 1'b0;
      data_en = 1'b0;
    end
    chk({tag, "_wait_req"}, 64'(mem_if.mem_req), 64'd0);
    for (int k = 0; k < do_d; k++) begin
      cancel = do_cancel && (k == 0);
      step();
      cancel = 1'b0;
      check_out({tag, "_wait"}, 1'b0, 1'b0);
    end
    if (do_d == 0) cancel = do_cancel;
    mem_if.mem_data_ok = 1'b1;
    mem_if.mem_rdata   = rd;
    step();
    cancel             = 1'b0;
    mem_if.mem_data_ok = 1'b0;
  endtask

  task automatic run_txn(input string tag, input bit is_data, input logic [3:0] wen,
                         input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input int ao_d, input int do_d, input logic [DW-1:0] rd,
                         input bit spurious, input bit do_cancel, input bit drop_en);
    if (is_data) begin
      data_en = 1'b1; data_wen = wen; data_addr = addr; data_wdata = wdata;
    end else begin
      inst_en = 1'b1; inst_addr = addr;
    end
    step();
    mem_serve(tag, addr, is_data && (wen != 4'h0), is_data ? wen : 4'h0, wdata,
              ao_d, do_d, rd, spurious, do_cancel, drop_en);
    if (!is_data) exp_inst_rdata = rd;
    else if (wen == 4'h0) exp_data_rdata = rd;
    check_out({tag, "_resp"}, !is_data && !do_cancel, is_data);
    inst_en = 1'b0;
    data_en = 1'b0;
    step();
    check_out({tag, "_idle"}, 1'b0, 1'b0);
    chk({tag, "_idle_req"}, 64'(mem_if.mem_req), 64'd0);
  endtask

  bit            r_isd, r_sp, r_cn, r_dr, sec_inst;
  logic [3:0]    r_wen;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wd, r_rd;
  int            r_ao, r_do;

  initial begin
    reset = 1'b1; cancel = 1'b0;
    inst_en = 1'b0; inst_addr = '0;
    data_en = 1'b0; data_wen = '0; data_addr = '0; data_wdata = '0;
    mem_if.mem_addr_ok = 1'b0; mem_if.mem_data_ok = 1'b0; mem_if.mem_rdata = '0;
    exp_inst_rdata = '0; exp_data_rdata = '0;
    step();
    step();
    reset = 1'b0;
    check_out("reset", 1'b0, 1'b0);
    chk("reset_req",  64'(mem_if.mem_req),  64'd0);
    chk("reset_addr", 64'(mem_if.mem_addr), 64'd0);
    chk("reset_wr",   64'(mem_if.mem_wr),   64'd0);
    step();

    run_txn("inst_rd", 1'b0, 4'h0, 32'hBFC0_0000, 32'h0, 0, 0, 32'h3C01_0001, 1'b0, 1'b0, 1'b0);
    run_txn("store", 1'b1, 4'b0011, 32'h8000_1004, 32'hDEAD_BEEF, 0, 0, 32'h5555_AAAA, 1'b0, 1'b0, 1'b0);
    run_txn("load", 1'b1, 4'h0, 32'h8000_2000, 32'h0, 1, 2, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0);
    run_txn("backp", 1'b0, 4'h0, 32'hBFC0_0010, 32'h0, 5, 1, 32'h0BAD_CAFE, 1'b1, 1'b0, 1'b0);
    run_txn("cancel", 1'b0, 4'h0, 32'hBFC0_0020, 32'h0, 0, 2, 32'h1234_5678, 1'b0, 1'b1, 1'b0);
    run_txn("post_cancel", 1'b0, 4'h0, 32'hBFC0_0024, 32'h0, 0, 0, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0);
    run_txn("cancel_data", 1'b1, 4'h0, 32'h8000_3000, 32'h0, 0, 1, 32'h7777_1111, 1'b0, 1'b1, 1'b0);
    run_txn("drop_en", 1'b1, 4'h0, 32'h8000_4000, 32'h0, 1, 1, 32'h9999_0000, 1'b0, 1'b0, 1'b1);

    // Reset while in WAIT: outputs clear, late data_ok is ignored.
    inst_en = 1'b1; inst_addr = 32'hBFC0_0100;
    step();
    chk("rstw_req", 64'(mem_if.mem_req), 64'd1);
    mem_if.mem_addr_ok = 1'b1;
    step();
    mem_if.mem_addr_ok = 1'b0;
    reset = 1'b1; inst_en = 1'b0;
    step();
    reset = 1'b0;
    exp_inst_rdata = '0; exp_data_rdata = '0;
    check_out("rstw", 1'b0, 1'b0);
    chk("rstw_req0",  64'(mem_if.mem_req),  64'd0);
    chk("rstw_addr0", 64'(mem_if.mem_addr), 64'd0);
    mem_if.mem_data_ok = 1'b1; mem_if.mem_rdata = 32'hFEED_FACE;
    step();
    mem_if.mem_data_ok = 1'b0;
    check_out("rstw_late", 1'b0, 1'b0);
    step();
    check_out("rstw_late2", 1'b0, 1'b0);
    chk("rstw_late_req", 64'(mem_if.mem_req), 64'd0);

    // Contention: first tie always goes to data; inst stays pending.
    data_en = 1'b1; data_wen = 4'h0; data_addr = 32'h8000_5000;
    inst_en = 1'b1; inst_addr = 32'hBFC0_0200;
    step();
    mem_serve("tie1", 32'h8000_5000, 1'b0, 4'h0, 32'h0, 0, 0, 32'h1111_2222, 1'b0, 1'b0, 1'b0);
    exp_data_rdata = 32'h1111_2222;
    check_out("tie1_resp", 1'b0, 1'b1);
    // Data re-requests (a store) while inst is still pending: second tie.
    data_wen = 4'hF; data_addr = 32'h8000_6000; data_wdata = 32'hA5A5_5A5A;
    step();
    check_out("tie1_idle", 1'b0, 1'b0);
    step();
    sec_inst = RR_MODE;
    mem_serve("tie2a", sec_inst ? 32'hBFC0_0200 : 32'h8000_6000, !sec_inst,
              sec_inst ? 4'h0 : 4'hF, 32'hA5A5_5A5A, 1, 1, 32'h3333_4444, 1'b0, 1'b0, 1'b0);
    if (sec_inst) exp_inst_rdata = 32'h3333_4444;
    check_out("tie2a_resp", sec_inst, !sec_inst);
    if (sec_inst) inst_en = 1'b0;
    else data_en = 1'b0;
    step();
    check_out("tie2a_idle", 1'b0, 1'b0);
    step();
    mem_serve("tie2b", sec_inst ? 32'h8000_6000 : 32'hBFC0_0200, sec_inst,
              sec_inst ? 4'hF : 4'h0, 32'hA5A5_5A5A, 0, 1, 32'h5555_6666, 1'b0, 1'b0, 1'b0);
    if (!sec_inst) exp_inst_rdata = 32'h5555_6666;
    check_out("tie2b_resp", !sec_inst, sec_inst);
    inst_en = 1'b0; data_en = 1'b0;
    step();
    check_out("tie2b_idle", 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      r_isd  = 1'($urandom_range(0, 1));
      r_wen  = (r_isd && ($urandom_range(0, 1) == 1)) ? 4'($urandom) : 4'h0;
      r_addr = $urandom;
      r_wd   = $urandom;
      r_rd   = $urandom;
      r_ao   = int'($urandom_range(0, 3));
      r_do   = int'($urandom_range(0, 3));
      r_sp   = 1'($urandom_range(0, 1));
      r_cn   = ($urandom_range(0, 3) == 0);
      r_dr   = ($urandom_range(0, 3) == 0);
      run_txn($sformatf("rnd%0d", i), r_isd, r_wen, r_addr, r_wd, r_ao, r_do, r_rd, r_sp, r_cn, r_dr);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
